// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, status codes,
// the "no register" ID and the jXX/cmovXX condition function codes.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator: maps a function code and
// the condition-code flags to the taken/move decision.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt_s;

    assign lt_s = sf ^ of;

    // Condition decode; unused function codes never fire.
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt_s | zf;
            C_L:     cnd = lt_s;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt_s;
            C_G:     cnd = ~lt_s & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory boundary: condition codes, cmov destination squash and
// the stallable/bubblable M pipeline register.
module ex_mem_stage
    import y86_pkg::*;
#(
    parameter int         WIDTH         = 64,
    parameter logic [3:0] REG_NONE_P    = REG_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [1:0]       E_stat,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic             m_exc,
    input  logic             W_exc,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic             e_cnd,
    output logic [3:0]       e_dstE,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic [3:0]       M_icode,
    output logic [1:0]       M_stat,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    logic             zf_q, sf_q, of_q;
    logic             zf_d, sf_d, of_d;
    logic [3:0]       icode_q, icode_d;
    logic [1:0]       stat_q, stat_d;
    logic             cnd_q, cnd_d;
    logic [WIDTH-1:0] vale_q, vale_d;
    logic [WIDTH-1:0] vala_q, vala_d;
    logic [3:0]       dste_q, dste_d;
    logic [3:0]       dstm_q, dstm_d;

    // Condition is evaluated against the pre-edge flags, so an OPq landing
    // on the same edge only influences the following instruction.
    cond_eval u_cond_eval (
        .ifun (E_ifun),
        .zf   (zf_q),
        .sf   (sf_q),
        .of   (of_q),
        .cnd  (e_cnd)
    );

    // A not-taken cmov must not write its destination.
    always_comb begin
        if ((E_icode == I_CMOVXX) && !e_cnd) begin
            e_dstE = REG_NONE_P;
        end else begin
            e_dstE = E_dstE;
        end
    end

    // Flags update only for OPq when no older instruction has faulted.
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if ((E_icode == I_OPQ) && !m_exc && !W_exc) begin
            zf_d = (alu_result == {WIDTH{1'b0}});
            sf_d = alu_result[WIDTH-1];
            of_d = alu_overflow;
        end else begin
            zf_d = zf_q;
            sf_d = sf_q;
            of_d = of_q;
        end
    end

    // M register next state: stall beats bubble, bubble beats normal load.
    always_comb begin
        icode_d = icode_q;
        stat_d  = stat_q;
        cnd_d   = cnd_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        if (M_stall) begin
            icode_d = icode_q;
        end else if (M_bubble) begin
            icode_d = I_NOP;
            stat_d  = STAT_AOK;
            cnd_d   = 1'b0;
            vale_d  = {WIDTH{1'b0}};
            vala_d  = {WIDTH{1'b0}};
            dste_d  = REG_NONE_P;
            dstm_d  = REG_NONE_P;
        end else begin
            icode_d = E_icode;
            stat_d  = E_stat;
            cnd_d   = e_cnd;
            vale_d  = alu_result;
            vala_d  = E_valA;
            dste_d  = e_dstE;
            dstm_d  = E_dstM;
        end
    end

    // Condition-code register with synchronous reset to "zero result".
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    // M pipeline register; reset leaves a NOP bundle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            icode_q <= I_NOP;
            stat_q  <= STAT_AOK;
            cnd_q   <= 1'b0;
            vale_q  <= {WIDTH{1'b0}};
            vala_q  <= {WIDTH{1'b0}};
            dste_q  <= REG_NONE_P;
            dstm_q  <= REG_NONE_P;
        end else begin
            icode_q <= icode_d;
            stat_q  <= stat_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
        end
    end

    assign cc_zf   = zf_q;
    assign cc_sf   = sf_q;
    assign cc_of   = of_q;
    assign M_icode = icode_q;
    assign M_stat  = stat_q;
    assign M_cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Params: WIDTH, default 64, datapath width; REG_NONE, default 4'hF, "no destination" register ID.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 E_icode  in  4  execute-stage instruction code.
REQ-005 E_ifun  in  4  execute-stage function code (condition selector for jXX/cmovXX).
REQ-006 E_stat  in  2  execute-stage status: 0=AOK, 1=HLT, 2=ADR, 3=INS.
REQ-007 alu_result  in  WIDTH  ALU output for the execute-stage instruction.
REQ-008 alu_overflow  in  1  ALU signed-overflow flag.
REQ-009 E_valA, E_dstE, E_dstM  in  WIDTH/4/4  operand A and destination register IDs.
REQ-010 m_exc, W_exc  in  1/1  memory-stage / write-back-stage status is non-AOK.
REQ-011 M_stall, M_bubble  in  1/1  pipeline-register control.
REQ-012 e_cnd, e_dstE  out  1/4  combinational condition result and adjusted destination.
REQ-013 cc_zf, cc_sf, cc_of  out  1 each  condition-code register contents.
REQ-014 M_icode, M_stat, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  4/2/1/WIDTH/WIDTH/4/4  registered memory-stage bundle.

Function
REQ-015 e_cnd by E_ifun, from current (pre-edge) CC: 0 true; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; 7-15 false.
REQ-016 e_dstE SHALL be REG_NONE when E_icode==2 (cmovXX) and e_cnd==0; otherwise E_dstE.
REQ-017 CC update when E_icode==6 (OPq) and m_exc==0 and W_exc==0: ZF<=(alu_result==0), SF<=alu_result[WIDTH-1], OF<=alu_overflow.
REQ-018 CC SHALL hold in all other cycles; M_stall and M_bubble do not affect CC.
REQ-019 M register normal load (no stall, no bubble): M_icode<=E_icode, M_stat<=E_stat, M_cnd<=e_cnd, M_valE<=alu_result, M_valA<=E_valA, M_dstE<=e_dstE, M_dstM<=E_dstM.
REQ-020 M_stall==1: all M outputs hold.
REQ-021 M_bubble==1, M_stall==0: M loads NOP bundle: icode=1, stat=AOK, cnd=0, valE=0, valA=0, dstE=dstM=REG_NONE.
REQ-022 M_stall and M_bubble both 1: stall wins (hold).
REQ-023 Latency: M outputs reflect execute-stage inputs exactly one cycle after capture; e_cnd/e_dstE zero-latency.
REQ-024 Same-edge CC update and cmov/jXX evaluation: e_cnd uses old CC; new CC visible from next cycle.
REQ-025 No arithmetic beyond zero test and sign extraction; widths of valE/valA pass unmodified.

Reset
REQ-026 rst==1 at an edge: ZF=1, SF=0, OF=0; M bundle = NOP bundle of REQ-021.
REQ-027 rst dominates M_stall, M_bubble and CC update in the same cycle.
REQ-028 rst mid-stream discards any in-flight M contents; first post-reset edge performs normal operation.

Structure
REQ-029 Shared package y86_pkg SHALL hold icode constants (NOP=1, CMOVXX=2, OPQ=6, JXX=7), stat codes, REG_NONE, condition function codes 0-6.
REQ-030 One sub-module cond_eval (combinational: ifun, zf, sf, of -> cnd); rest in ex_mem_stage.

Verification
REQ-031 Reset: rst=1 one cycle -> ZF=1, SF=0, OF=0, M_icode=1, M_dstE=M_dstM=F, M_stat=0.
REQ-032 OPq, alu_result=0, overflow=0 -> next cycle ZF=1, SF=0, OF=0; alu_result=0x8000_0000_0000_0000, overflow=1 -> ZF=0, SF=1, OF=1.
REQ-033 Same OPq with m_exc=1 -> CC unchanged; M_valE still captures alu_result.
REQ-034 CC ZF=0,SF=1,OF=0; cmovXX ifun=3 E_dstE=4 -> e_cnd=0, e_dstE=F; ifun=2 -> e_cnd=1, e_dstE=4.
REQ-035 M_stall=1 two cycles with changing inputs -> M outputs frozen; M_bubble=1 -> M_icode=1, M_valE=0; both asserted -> hold.
REQ-036 Back-to-back OPq (result -5) then jXX ifun=1 -> jXX e_cnd=1 using CC updated by prior OPq.
